// File: rtl/ariane_pkg.sv
// ariane_pkg: shared decode/issue types for the issue-side slice.
//   ISSUE_FIFO_DEPTH    default depth of the decode->issue elastic buffer
//   fu_t                functional-unit selector carried by each decoded entry
//   scoreboard_entry_t  decoded instruction record passed from decode to issue
package ariane_pkg;

    localparam int unsigned ISSUE_FIFO_DEPTH = 4;

    typedef enum logic [2:0] {
        NONE,
        LOAD,
        STORE,
        ALU,
        CTRL_FLOW,
        MULT,
        CSR
    } fu_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [2:0]  trans_id;
        fu_t         fu;
        logic [7:0]  op;
        logic [5:0]  rs1;
        logic [5:0]  rs2;
        logic [5:0]  rd;
        logic [63:0] result;
        logic        valid;
        logic        use_imm;
    } scoreboard_entry_t;

endpackage

// File: rtl/issue_entry_fifo.sv
// issue_entry_fifo: elastic buffer between decode and the load/store reorder stage.
// Zero-latency fall-through when empty, one-entry lookahead (peek) behind the head,
// flushed together with the frontend.
//
// Ports:
//   clk_i, rst_ni                      clock, synchronous active-low reset
//   flush_i                            drop all buffered entries
//   issue_entry_i / _valid_i           decoded entry from decode
//   is_ctrl_flow_i                     entry is control flow
//   issue_instr_ack_o                  entry accepted this cycle (to decode)
//   issue_entry_o / _valid_o           head entry (to reorder stage)
//   is_ctrl_flow_o                     head is control flow
//   issue_instr_ack_i                  head consumed this cycle
//   peek_entry_o / peek_valid_o        entry behind head
//   count_o                            stored entries (fall-through not counted)
//
// Optional build macro ISSUE_FIFO_STATS_EN adds:
//   full_stall_cnt_o                   saturating count of cycles stalled on a full buffer
//   max_occupancy_o                    high-water mark of count_o
// Both are cleared by reset only.
module issue_entry_fifo
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH = ISSUE_FIFO_DEPTH
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  scoreboard_entry_t          issue_entry_i,
    input  logic                       issue_entry_valid_i,
    input  logic                       is_ctrl_flow_i,
    output logic                       issue_instr_ack_o,
    output scoreboard_entry_t          issue_entry_o,
    output logic                       issue_entry_valid_o,
    output logic                       is_ctrl_flow_o,
    input  logic                       issue_instr_ack_i,
    output scoreboard_entry_t          peek_entry_o,
    output logic                       peek_valid_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
`ifdef ISSUE_FIFO_STATS_EN
    ,
    output logic [31:0]                full_stall_cnt_o,
    output logic [$clog2(DEPTH+1)-1:0] max_occupancy_o
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        scoreboard_entry_t sbe;
        logic              is_ctrl_flow;
    } fifo_entry_t;

    fifo_entry_t      mem_q [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_nxt;

    logic active;
    logic empty;
    logic full;
    logic push;
    logic pop;
    logic push_store;
    logic pop_store;

    // DEPTH need not be a power of two, so wrap on an explicit compare.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign rd_ptr_nxt = ptr_inc(rd_ptr_q);

    always_comb begin
        active              = rst_ni & ~flush_i;
        // ack_i -> ack_o is combinational: a full buffer accepts while it is drained.
        issue_instr_ack_o   = rst_ni & (flush_i | ~full | issue_instr_ack_i);

        issue_entry_o       = issue_entry_i;
        is_ctrl_flow_o      = is_ctrl_flow_i;
        issue_entry_valid_o = active & issue_entry_valid_i;
        if (!empty) begin
            issue_entry_o       = mem_q[rd_ptr_q].sbe;
            is_ctrl_flow_o      = mem_q[rd_ptr_q].is_ctrl_flow;
            issue_entry_valid_o = active;
        end

        // With a single stored entry the lookahead is whatever decode offers now.
        peek_entry_o = issue_entry_i;
        peek_valid_o = 1'b0;
        if (count_q >= CNT_W'(2)) begin
            peek_entry_o = mem_q[rd_ptr_nxt].sbe;
            peek_valid_o = active;
        end else if (!empty) begin
            peek_valid_o = active & issue_entry_valid_i;
        end

        push       = active & issue_entry_valid_i & issue_instr_ack_o;
        pop        = issue_entry_valid_o & issue_instr_ack_i;
        // Empty with push and pop together: the entry falls straight through.
        push_store = push & ~(empty & pop);
        pop_store  = pop & ~empty;
    end

    assign count_o = rst_ni ? count_q : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            if (push_store) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop_store) begin
                rd_ptr_q <= rd_ptr_nxt;
            end
            count_q <= count_q + CNT_W'(push_store) - CNT_W'(pop_store);
        end
    end

    // Storage is not reset; validity is carried by count_q alone.
    always_ff @(posedge clk_i) begin
        if (push_store) begin
            mem_q[wr_ptr_q] <= '{sbe: issue_entry_i, is_ctrl_flow: is_ctrl_flow_i};
        end
    end

`ifdef ISSUE_FIFO_STATS_EN
    logic [31:0]      full_stall_cnt_q;
    logic [CNT_W-1:0] max_occupancy_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            full_stall_cnt_q <= '0;
            max_occupancy_q  <= '0;
        end else begin
            if (full && issue_entry_valid_i && !issue_instr_ack_i && (full_stall_cnt_q != '1)) begin
                full_stall_cnt_q <= full_stall_cnt_q + 32'd1;
            end
            if (count_q > max_occupancy_q) begin
                max_occupancy_q <= count_q;
            end
        end
    end

    assign full_stall_cnt_o = full_stall_cnt_q;
    assign max_occupancy_o  = max_occupancy_q;
`else
    // Statistics counters not built in this configuration.
`endif

endmodule

// File: tb/tb_issue_entry_fifo.sv
// tb_issue_entry_fifo: directed self-checking bench for issue_entry_fifo (DEPTH=4).
// Build with ISSUE_FIFO_STATS_EN defined to also exercise the statistics ports.
module tb_issue_entry_fifo;
    import ariane_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic              clk_i;
    logic              rst_ni;
    logic              flush_i;
    scoreboard_entry_t issue_entry_i;
    logic              issue_entry_valid_i;
    logic              is_ctrl_flow_i;
    logic              issue_instr_ack_o;
    scoreboard_entry_t issue_entry_o;
    logic              issue_entry_valid_o;
    logic              is_ctrl_flow_o;
    logic              issue_instr_ack_i;
    scoreboard_entry_t peek_entry_o;
    logic              peek_valid_o;
    logic [CNT_W-1:0]  count_o;
`ifdef ISSUE_FIFO_STATS_EN
    logic [31:0]       full_stall_cnt_o;
    logic [CNT_W-1:0]  max_occupancy_o;
`endif

    int unsigned vectors;
    int unsigned miscompares;

    issue_entry_fifo #(.DEPTH(DEPTH)) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .flush_i             (flush_i),
        .issue_entry_i       (issue_entry_i),
        .issue_entry_valid_i (issue_entry_valid_i),
        .is_ctrl_flow_i      (is_ctrl_flow_i),
        .issue_instr_ack_o   (issue_instr_ack_o),
        .issue_entry_o       (issue_entry_o),
        .issue_entry_valid_o (issue_entry_valid_o),
        .is_ctrl_flow_o      (is_ctrl_flow_o),
        .issue_instr_ack_i   (issue_instr_ack_i),
        .peek_entry_o        (peek_entry_o),
        .peek_valid_o        (peek_valid_o),
        .count_o             (count_o)
`ifdef ISSUE_FIFO_STATS_EN
        ,
        .full_stall_cnt_o    (full_stall_cnt_o),
        .max_occupancy_o     (max_occupancy_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic scoreboard_entry_t mk(input logic [63:0] pc);
        scoreboard_entry_t e;
        e          = '0;
        e.pc       = pc;
        e.trans_id = pc[4:2];
        e.fu       = ALU;
        e.op       = pc[7:0] ^ 8'h5a;
        e.rd       = pc[7:2];
        e.valid    = 1'b1;
        return e;
    endfunction

    // Advance one clock; inputs are driven 1 ns after the edge, outputs sampled 2 ns after.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] pc, input logic ack, input logic cf);
        issue_entry_valid_i = v;
        issue_entry_i       = mk(pc);
        issue_instr_ack_i   = ack;
        is_ctrl_flow_i      = cf;
        #1;
    endtask

    logic [63:0] q[$];
    logic [63:0] popped;
    logic [63:0] in_pc;
    logic        exp_ack;
    logic        exp_valid;
    logic        do_push;
    logic        do_pop;
    int unsigned sent;
    int unsigned recv;
    int unsigned cycles;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_ni      = 1'b0;
        flush_i     = 1'b0;
        drive(1'b1, 64'h40, 1'b1, 1'b0);

        // Reset: outputs forced idle even with valid input present
        check("rst_valid_o", 64'(issue_entry_valid_o), 64'd0);
        check("rst_ack_o",   64'(issue_instr_ack_o),   64'd0);
        check("rst_peek_v",  64'(peek_valid_o),        64'd0);
        check("rst_count",   64'(count_o),             64'd0);
        step();
        step();
        check("rst_count2",  64'(count_o),             64'd0);

        rst_ni = 1'b1;
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        step();

        // Fall-through
        drive(1'b1, 64'h80, 1'b1, 1'b0);
        check("ft_valid", 64'(issue_entry_valid_o), 64'd1);
        check("ft_pc",    issue_entry_o.pc,         64'h80);
        check("ft_ack",   64'(issue_instr_ack_o),   64'd1);
        check("ft_peekv", 64'(peek_valid_o),        64'd0);
        step();
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        check("ft_count", 64'(count_o), 64'd0);

        // Fill to DEPTH; 0x88 marked control flow
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'h80 + 64'(4 * i), 1'b0, (i == 2));
            check("fill_ack", 64'(issue_instr_ack_o), 64'd1);
            step();
        end
        drive(1'b1, 64'h90, 1'b0, 1'b0);
        check("full_count", 64'(count_o),           64'd4);
        check("full_ack",   64'(issue_instr_ack_o), 64'd0);
        check("full_head",  issue_entry_o.pc,       64'h80);
        check("full_peek",  peek_entry_o.pc,        64'h84);
        check("full_peekv", 64'(peek_valid_o),      64'd1);
        step();
        check("full_hold",  64'(count_o),           64'd4);

        // Full + pop accepts the new entry
        drive(1'b1, 64'h90, 1'b1, 1'b0);
        check("fp_ack",  64'(issue_instr_ack_o), 64'd1);
        check("fp_head", issue_entry_o.pc,       64'h80);
        step();
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        check("fp_count", 64'(count_o), 64'd4);

        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 64'h0, 1'b1, 1'b0);
            check("drain_valid", 64'(issue_entry_valid_o), 64'd1);
            check("drain_pc",    issue_entry_o.pc,         64'h84 + 64'(4 * i));
            check("drain_cf",    64'(is_ctrl_flow_o),      64'(i == 1));
            if (i == 3) check("drain_peek1", 64'(peek_valid_o), 64'd0);
            step();
        end
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        check("drain_empty", 64'(issue_entry_valid_o), 64'd0);
        check("drain_count", 64'(count_o),             64'd0);

        // Streams with random back-pressure against a queue model
        q.delete();
        sent   = 0;
        recv   = 0;
        cycles = 0;
        while ((sent < 30 || q.size() != 0) && cycles < 500) begin
            in_pc = 64'h100 + 64'(4 * sent);
            drive(sent < 30, in_pc, 1'($urandom_range(0, 1)), 1'b0);
            exp_ack   = (q.size() < DEPTH) || issue_instr_ack_i;
            exp_valid = (q.size() != 0) || issue_entry_valid_i;
            check("st_ack",   64'(issue_instr_ack_o),   64'(exp_ack));
            check("st_valid", 64'(issue_entry_valid_o), 64'(exp_valid));
            check("st_count", 64'(count_o),             64'(q.size()));
            if (exp_valid) check("st_head", issue_entry_o.pc, (q.size() != 0) ? q[0] : in_pc);
            if (q.size() >= 2) check("st_peek", peek_entry_o.pc, q[1]);
            do_push = issue_entry_valid_i && exp_ack;
            do_pop  = exp_valid && issue_instr_ack_i;
            if (do_push) begin
                q.push_back(in_pc);
                sent++;
            end
            if (do_pop) begin
                popped = q.pop_front();
                check("st_order", popped, 64'h100 + 64'(4 * recv));
                recv++;
            end
            step();
            cycles++;
        end
        check("st_done", 64'(recv), 64'd30);

        // Flush with three stored entries
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'h180 + 64'(4 * i), 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 64'h1a0, 1'b0, 1'b0);
        check("fl_count", 64'(count_o), 64'd3);
        flush_i = 1'b1;
        #1;
        check("fl_valid", 64'(issue_entry_valid_o), 64'd0);
        check("fl_ack",   64'(issue_instr_ack_o),   64'd1);
        check("fl_peekv", 64'(peek_valid_o),        64'd0);
        step();
        flush_i = 1'b0;
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        check("fl_count0", 64'(count_o),      64'd0);
        check("fl_peekv0", 64'(peek_valid_o), 64'd0);
        drive(1'b1, 64'h200, 1'b0, 1'b0);
        check("fl_ft_pc", issue_entry_o.pc, 64'h200);
        step();
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        check("fl_store_pc", issue_entry_o.pc, 64'h200);
        step();
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        check("fl_after", 64'(count_o), 64'd0);

`ifdef ISSUE_FIFO_STATS_EN
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        check("stat_rst_max", 64'(max_occupancy_o), 64'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'h300 + 64'(4 * i), 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 64'h310, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step();
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        check("stat_stall", 64'(full_stall_cnt_o), 64'd7);
        check("stat_max",   64'(max_occupancy_o),  64'd4);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        step();
        check("stat_fl_stall", 64'(full_stall_cnt_o), 64'd7);
        check("stat_fl_max",   64'(max_occupancy_o),  64'd4);
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        check("stat_rst_stall", 64'(full_stall_cnt_o), 64'd0);
        check("stat_rst_max2",  64'(max_occupancy_o),  64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
